// File: rtl/fft_serial_pkg.sv
// Shared types and width helpers for the FFT serial output path.
package fft_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    FLUSH
  } pts_tx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Divider width; a period of 1 still needs a one-bit register.
  function automatic int div_w(input int clks_per_bit);
    return max_int(1, $clog2(clks_per_bit));
  endfunction

  // The bit counter also counts gap bits, so it must hold whichever is larger.
  function automatic int bit_cnt_w(input int num_bits, input int gap_bits);
    return max_int($clog2(num_bits + 1), $clog2(gap_bits + 1));
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Free-running divider with terminal-count pulse; tc is combinational on count.
// Latency: tc every PERIOD enabled cycles after clear; no backpressure.
module tx_bit_timer
  import fft_serial_pkg::*;
#(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = div_w(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] count;

  assign tc = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pts_tx_ctrl.sv
// Transmit sequencer for the parallel-to-serial shift register: load, paced shifts, gap.
// Latency: sr_load one cycle after accept; in_ready low from accept until the gap ends.
module pts_tx_ctrl
  import fft_serial_pkg::*;
#(
  parameter int NUM_BITS     = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                abort,
  output logic                sr_load,
  output logic                sr_shift,
  output logic [NUM_BITS-1:0] sr_data,
  output logic                busy,
  output logic                frame_done
);

  localparam int BCW = bit_cnt_w(NUM_BITS, GAP_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NUM_BITS - 1);
  localparam logic [BCW-1:0] LAST_GAP = BCW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  pts_tx_state_t state, next_state;
  logic [BCW-1:0] bit_cnt;
  logic           timer_en;
  logic           tick;
  logic           do_abort;
  logic           shift_now;
  logic           last_shift;
  logic           gap_end;

  assign timer_en   = (state == SHIFT) || (state == GAP);
  assign do_abort   = abort && (state inside {LOAD, SHIFT, GAP});
  // An abort in the same cycle suppresses any strobe that was due.
  assign shift_now  = (state == SHIFT) && tick && !abort;
  assign last_shift = shift_now && (bit_cnt == LAST_BIT);
  assign gap_end    = (state == GAP) && tick && (bit_cnt == LAST_GAP);

  tx_bit_timer #(
    .PERIOD (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (!timer_en),
    .enable (timer_en),
    .tc     (tick)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (do_abort) begin
      next_state = FLUSH;
    end else begin
      case (state)
        IDLE:    if (in_valid) next_state = LOAD;
        LOAD:    next_state = SHIFT;
        SHIFT:   if (last_shift) next_state = (GAP_BITS > 0) ? GAP : IDLE;
        GAP:     if (gap_end) next_state = IDLE;
        FLUSH:   next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Counts data bits in SHIFT, then reused to count gap bits in GAP.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bit_cnt <= '0;
    end else begin
      case (state)
        SHIFT:   if (shift_now) bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        GAP:     if (tick) bit_cnt <= bit_cnt + 1'b1;
        default: bit_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sr_data <= '1;
    end else if (do_abort) begin
      sr_data <= '1;
    end else if ((state == IDLE) && in_valid) begin
      sr_data <= in_data;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b1;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      LOAD, FLUSH: sr_load = 1'b1;
      SHIFT: begin
        sr_shift   = shift_now;
        frame_done = last_shift;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Bench for pts_tx_ctrl: a 16/4/1 instance with a shift-register line model,
// plus a 16/1/0 instance for back-to-back pacing.
module tb_pts_tx_ctrl;

  localparam int N = 16;
  localparam int C = 4;
  localparam int G = 1;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         abort = 1'b0;
  logic         in_ready, sr_load, sr_shift, busy, frame_done;
  logic [N-1:0] sr_data;

  logic [N-1:0] in_data_b = '0;
  logic         in_valid_b = 1'b0;
  logic         abort_b = 1'b0;
  logic         in_ready_b, sr_load_b, sr_shift_b, busy_b, frame_done_b;
  logic [N-1:0] sr_data_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  pts_tx_ctrl #(.NUM_BITS(N), .CLKS_PER_BIT(C), .GAP_BITS(G)) dut (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .sr_load(sr_load), .sr_shift(sr_shift),
    .sr_data(sr_data), .busy(busy), .frame_done(frame_done)
  );

  pts_tx_ctrl #(.NUM_BITS(N), .CLKS_PER_BIT(1), .GAP_BITS(0)) dut_b (
    .clk(clk), .n_rst(n_rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .abort(abort_b), .sr_load(sr_load_b), .sr_shift(sr_shift_b),
    .sr_data(sr_data_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External shift register: MSB-first, fills with ones, line is the MSB.
  logic [N-1:0] sreg;
  always @(posedge clk) begin
    if (!n_rst)        sreg <= '1;
    else if (sr_load)  sreg <= sr_data;
    else if (sr_shift) sreg <= {sreg[N-2:0], 1'b1};
  end
  wire serial = sreg[N-1];

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({sr_load, sr_shift, frame_done} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got=%b exp=000", {sr_load, sr_shift, frame_done}); end
    checks++; if (sr_data !== 16'hFFFF) begin errors++; $display("FAIL reset_sr_data got=%h exp=ffff", sr_data); end
    checks++; if (serial !== 1'b1) begin errors++; $display("FAIL reset_line got=%b exp=1", serial); end
    checks++; if ({in_ready_b, busy_b, sr_data_b} !== {2'b10, 16'hFFFF}) begin
      errors++; $display("FAIL reset_b got=%b%b/%h exp=10/ffff", in_ready_b, busy_b, sr_data_b); end
  endtask

  task automatic test_single_frame(input logic [N-1:0] w, input string name);
    int t, c, e, rdy_at, idx;
    logic exp_bit;
    int q_load[$], q_shift[$], q_done[$];
    @(negedge clk);
    for (int i = 0; i < 300 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_idle_wait in_ready=%b exp=1", name, in_ready); return;
    end
    in_data = w; in_valid = 1'b1; t = cyc;
    q_load.push_back(t + 1);
    for (int k = 1; k <= N; k++) q_shift.push_back(t + 1 + k * C);
    q_done.push_back(t + 1 + N * C);
    rdy_at = t + 2 + (N + G) * C;
    for (int i = 1; i <= (N + G) * C + 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_data = ~w;
      #1; c = cyc;
      if (sr_load === 1'b1) begin
        checks++; e = (q_load.size() > 0) ? q_load.pop_front() : -1;
        if (c !== e) begin errors++; $display("FAIL %s_load cycle=%0d exp=%0d", name, c - t, e - t); end
      end
      if (sr_shift === 1'b1) begin
        checks++; e = (q_shift.size() > 0) ? q_shift.pop_front() : -1;
        if (c !== e) begin errors++; $display("FAIL %s_shift cycle=%0d exp=%0d", name, c - t, e - t); end
      end
      if (frame_done === 1'b1) begin
        checks++; e = (q_done.size() > 0) ? q_done.pop_front() : -1;
        if (c !== e) begin errors++; $display("FAIL %s_done cycle=%0d exp=%0d", name, c - t, e - t); end
      end
      checks++; if ((sr_load & sr_shift) !== 1'b0) begin
        errors++; $display("FAIL %s_overlap at cycle=%0d", name, c - t); end
      if (c == t + 1) begin
        checks++; if (sr_data !== w) begin errors++; $display("FAIL %s_load_data got=%h exp=%h", name, sr_data, w); end
      end
      if (c >= t + 2) begin
        idx = N - 1 - (c - t - 2) / C;
        exp_bit = (c <= t + 1 + N * C) ? w[idx] : 1'b1;
        checks++; if (serial !== exp_bit) begin
          errors++; $display("FAIL %s_line cycle=%0d got=%b exp=%b", name, c - t, serial, exp_bit); end
      end
      checks++; if (in_ready !== (c >= rdy_at)) begin
        errors++; $display("FAIL %s_in_ready cycle=%0d got=%b exp=%b", name, c - t, in_ready, c >= rdy_at); end
      checks++; if (busy !== (c < rdy_at)) begin
        errors++; $display("FAIL %s_busy cycle=%0d got=%b exp=%b", name, c - t, busy, c < rdy_at); end
    end
    checks++; if (q_load.size() + q_shift.size() + q_done.size() != 0) begin
      errors++; $display("FAIL %s_missing load=%0d shift=%0d done=%0d exp=0", name,
                         q_load.size(), q_shift.size(), q_done.size()); end
  endtask

  task automatic test_back_to_back(input logic [N-1:0] w1, input logic [N-1:0] w2);
    int t, c, e;
    int q_acc[$], q_load[$], q_shift[$], q_done[$];
    @(negedge clk);
    for (int i = 0; i < 300 && in_ready_b !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready_b !== 1'b1) begin errors++; $display("FAIL b2b_idle_wait in_ready=%b exp=1", in_ready_b); return; end
    in_data_b = w1; in_valid_b = 1'b1; t = cyc;
    q_acc.push_back(t + 18);
    q_load.push_back(t + 1); q_load.push_back(t + 19);
    for (int k = 1; k <= N; k++) begin q_shift.push_back(t + 1 + k); end
    for (int k = 1; k <= N; k++) begin q_shift.push_back(t + 19 + k); end
    q_done.push_back(t + 17); q_done.push_back(t + 35);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      c = cyc;
      in_data_b = w2; in_valid_b = (c <= t + 18);
      #1;
      if (in_valid_b && in_ready_b) begin
        checks++; e = (q_acc.size() > 0) ? q_acc.pop_front() : -1;
        if (c !== e) begin errors++; $display("FAIL b2b_accept cycle=%0d exp=%0d", c - t, e - t); end
      end
      if (sr_load_b === 1'b1) begin
        checks++; e = (q_load.size() > 0) ? q_load.pop_front() : -1;
        if (c !== e) begin errors++; $display("FAIL b2b_load cycle=%0d exp=%0d", c - t, e - t); end
      end
      if (sr_shift_b === 1'b1) begin
        checks++; e = (q_shift.size() > 0) ? q_shift.pop_front() : -1;
        if (c !== e) begin errors++; $display("FAIL b2b_shift cycle=%0d exp=%0d", c - t, e - t); end
      end
      if (frame_done_b === 1'b1) begin
        checks++; e = (q_done.size() > 0) ? q_done.pop_front() : -1;
        if (c !== e) begin errors++; $display("FAIL b2b_done cycle=%0d exp=%0d", c - t, e - t); end
      end
      checks++; if ((sr_load_b & sr_shift_b) !== 1'b0) begin
        errors++; $display("FAIL b2b_overlap at cycle=%0d", c - t); end
      if (c == t + 19) begin
        checks++; if (sr_data_b !== w2) begin errors++; $display("FAIL b2b_word2 got=%h exp=%h", sr_data_b, w2); end
      end
    end
    in_valid_b = 1'b0;
    checks++; if (q_acc.size() + q_load.size() + q_shift.size() + q_done.size() != 0) begin
      errors++; $display("FAIL b2b_missing acc=%0d load=%0d shift=%0d done=%0d exp=0",
                         q_acc.size(), q_load.size(), q_shift.size(), q_done.size()); end
  endtask

  task automatic test_abort(input logic [N-1:0] w);
    int t, c, e;
    int q_load[$], q_shift[$];
    @(negedge clk);
    for (int i = 0; i < 300 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_idle_wait in_ready=%b exp=1", in_ready); return; end
    in_data = w; in_valid = 1'b1; t = cyc;
    q_load.push_back(t + 1); q_load.push_back(t + 10);
    q_shift.push_back(t + 5);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      c = cyc;
      in_valid = 1'b0; abort = (c == t + 9);
      #1;
      if (sr_load === 1'b1) begin
        checks++; e = (q_load.size() > 0) ? q_load.pop_front() : -1;
        if (c !== e) begin errors++; $display("FAIL abort_load cycle=%0d exp=%0d", c - t, e - t); end
      end
      if (sr_shift === 1'b1) begin
        checks++; e = (q_shift.size() > 0) ? q_shift.pop_front() : -1;
        if (c !== e) begin errors++; $display("FAIL abort_shift cycle=%0d exp=%0d", c - t, e - t); end
      end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL abort_done cycle=%0d got=1 exp=0", c - t); end
      if (c == t + 10) begin
        checks++; if (sr_data !== 16'hFFFF) begin errors++; $display("FAIL abort_flush_data got=%h exp=ffff", sr_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_flush_ready got=%b exp=0", in_ready); end
      end
      if (c == t + 11) begin
        checks++; if ({in_ready, busy} !== 2'b10) begin
          errors++; $display("FAIL abort_idle ready/busy got=%b%b exp=10", in_ready, busy); end
        checks++; if (serial !== 1'b1) begin errors++; $display("FAIL abort_line got=%b exp=1", serial); end
      end
    end
    abort = 1'b0;
    checks++; if (q_load.size() + q_shift.size() != 0) begin
      errors++; $display("FAIL abort_missing load=%0d shift=%0d exp=0", q_load.size(), q_shift.size()); end
  endtask

  task automatic test_reset_midframe(input logic [N-1:0] w);
    int t, c;
    @(negedge clk);
    for (int i = 0; i < 300 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle_wait in_ready=%b exp=1", in_ready); return; end
    in_data = w; in_valid = 1'b1; t = cyc;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      c = cyc;
      in_valid = 1'b0; n_rst = (c != t + 20);
    end
    #1;
    checks++; if ({in_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL rstmid_ready_busy got=%b%b exp=10", in_ready, busy); end
    checks++; if ({sr_load, sr_shift, frame_done} !== 3'b000) begin
      errors++; $display("FAIL rstmid_strobes got=%b exp=000", {sr_load, sr_shift, frame_done}); end
    checks++; if (sr_data !== 16'hFFFF) begin errors++; $display("FAIL rstmid_sr_data got=%h exp=ffff", sr_data); end
    test_single_frame(16'h3C5A, "after_rst");
  endtask

  task automatic test_backpressure(input logic [N-1:0] w1, input logic [N-1:0] w2);
    int t, c;
    @(negedge clk);
    for (int i = 0; i < 300 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_wait in_ready=%b exp=1", in_ready); return; end
    in_data = w1; in_valid = 1'b1; t = cyc;
    for (int i = 1; i <= (N + G) * C + 2; i++) begin
      @(negedge clk);
      c = cyc;
      in_data = w2; in_valid = (c <= t + 2 + (N + G) * C);
      #1;
      if (c >= t + 2 && c < t + 2 + (N + G) * C) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cycle=%0d got=1 exp=0", c - t); end
        checks++; if (sr_data !== w1) begin errors++; $display("FAIL bp_hold cycle=%0d got=%h exp=%h", c - t, sr_data, w1); end
      end
      if (c == t + 2 + (N + G) * C) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got=%b exp=1", in_ready); end
      end
      if (c == t + 3 + (N + G) * C) begin
        checks++; if ({sr_load, sr_data} !== {1'b1, w2}) begin
          errors++; $display("FAIL bp_capture got=%b/%h exp=1/%h", sr_load, sr_data, w2); end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 300 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain in_ready=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_frame(16'hA5C3, "frame_a5c3");
    test_single_frame(16'h8001, "frame_8001");
    test_single_frame(16'($urandom), "frame_rand");
    test_back_to_back(16'h1234, 16'hBEEF);
    test_abort(16'h0F0F);
    test_reset_midframe(16'h5555);
    test_backpressure(16'hC001, 16'h7E7E);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
